// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared state encoding and bus widths for the OV7670 capture path.
package ov7670_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;
  localparam int PIX_W  = 16;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/ov7670_in_sync.sv
// ov7670_in_sync: oversamples the camera pins into the system clock and derives edge strobes.
module ov7670_in_sync
  import ov7670_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              pclk_i,
  input  logic              vsync_i,
  input  logic              href_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic              href_o,
  output logic [BYTE_W-1:0] data_o,
  output logic              pclk_rise_o,
  output logic              vs_rise_o,
  output logic              vs_fall_o,
  output logic              href_fall_o
);
  // Bit order {pclk, vsync, href}; data shares the same two-flop latency so it lines up with pclk
  logic [2:0]        m_q, s_q, h_q;
  logic [BYTE_W-1:0] dm_q, ds_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_q  <= '0;
      s_q  <= '0;
      h_q  <= '0;
      dm_q <= '0;
      ds_q <= '0;
    end else begin
      m_q  <= {pclk_i, vsync_i, href_i};
      s_q  <= m_q;
      h_q  <= s_q;
      dm_q <= data_i;
      ds_q <= dm_q;
    end
  end
  assign href_o      = s_q[0];
  assign data_o      = ds_q;
  assign pclk_rise_o = s_q[2] & ~h_q[2];
  assign vs_rise_o   = s_q[1] & ~h_q[1];
  assign vs_fall_o   = ~s_q[1] & h_q[1];
  assign href_fall_o = ~s_q[0] & h_q[0];
endmodule

// File: rtl/ov7670_capture.sv
// ov7670_capture: frame-synchronised RGB565 packer writing pixels linearly into a frame buffer.
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              SYS_CLK,
  input  logic              RST_N,
  input  logic              RUN_EN,
  input  logic              CAM_PCLK,
  input  logic              CAM_VSYNC,
  input  logic              CAM_HREF,
  input  logic [BYTE_W-1:0] CAM_DATA,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [PIX_W-1:0]  WR_DATA,
  output logic              WR_FRAME,
  output logic              FRAME_ERR
);
  localparam int COL_W  = $clog2(H_PIXELS + 1);
  localparam int LINE_W = $clog2(V_LINES + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_PIXELS * V_LINES - 1);
  state_t              state_q;
  logic                phase_q, wr_en_q, wr_frame_q, frame_err_q;
  logic [BYTE_W-1:0]   hi_q;
  logic [COL_W-1:0]    col_q;
  logic [LINE_W-1:0]   line_q;
  logic [ADDR_W-1:0]   base_q, wr_addr_q, addr_d;
  logic [PIX_W-1:0]    wr_data_q;
  logic                href_s, pclk_rise, vs_rise, vs_fall, href_fall;
  logic                pix_ok, last_d, wr_go;
  logic [BYTE_W-1:0]   data_s;
  ov7670_in_sync u_sync (
    .clk_i(SYS_CLK), .rst_n_i(RST_N), .pclk_i(CAM_PCLK), .vsync_i(CAM_VSYNC),
    .href_i(CAM_HREF), .data_i(CAM_DATA), .href_o(href_s), .data_o(data_s),
    .pclk_rise_o(pclk_rise), .vs_rise_o(vs_rise), .vs_fall_o(vs_fall), .href_fall_o(href_fall)
  );
  assign addr_d = base_q + ADDR_W'(col_q);
  assign pix_ok = (col_q < COL_W'(H_PIXELS)) && (line_q < LINE_W'(V_LINES));
  assign last_d = addr_d == LAST;
  // A final pixel coinciding with vs_rise still completes the frame
  assign wr_go  = (state_q == CAPTURE) && RUN_EN && pclk_rise && href_s && phase_q && pix_ok
                  && (last_d || !vs_rise);
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      col_q       <= '0;
      line_q      <= '0;
      base_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_frame_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_en_q     <= wr_go;
      frame_err_q <= 1'b0;
      if (wr_go) begin
        wr_addr_q <= addr_d;
        wr_data_q <= {hi_q, data_s};
      end
      case (state_q)
        IDLE: state_q <= RUN_EN ? WAIT_VS : IDLE;
        WAIT_VS: begin
          state_q <= !RUN_EN ? IDLE : vs_fall ? CAPTURE : WAIT_VS;
          col_q   <= '0;
          line_q  <= '0;
          base_q  <= '0;
          phase_q <= 1'b0;
        end
        CAPTURE: begin
          if (!RUN_EN) state_q <= IDLE;
          else if (wr_go && last_d) state_q <= DONE;
          else if (vs_rise) begin
            frame_err_q <= 1'b1;
            state_q     <= WAIT_VS;
          end else if (pclk_rise && href_s) begin
            phase_q <= ~phase_q;
            if (!phase_q) hi_q <= data_s;
            if (wr_go) col_q <= col_q + 1'b1;
          end else if (href_fall) begin
            if (col_q != '0 && line_q < LINE_W'(V_LINES)) begin
              line_q <= line_q + 1'b1;
              base_q <= base_q + ADDR_W'(H_PIXELS);
            end
            col_q   <= '0;
            phase_q <= 1'b0;
          end
        end
        DONE: begin
          wr_frame_q <= RUN_EN;
          if (!RUN_EN) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign WR_EN     = wr_en_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_DATA   = wr_data_q;
  assign WR_FRAME  = wr_frame_q;
  assign FRAME_ERR = frame_err_q;
endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture: directed scenarios for the capture stage on a 4x2 frame, SYS_CLK = 4x PCLK.
module tb_ov7670_capture;
  logic       clk = 1'b0, rst_n = 1'b0, run_en = 1'b0;
  logic       pclk = 1'b0, vsync = 1'b0, href = 1'b0;
  logic [7:0] cdata = '0;
  logic       wr_en, wr_frame, frame_err;
  logic [2:0] wr_addr;
  logic [15:0] wr_data;
  int n_tests = 0, n_fail = 0;
  int nw = 0, errcnt = 0, errlong = 0;
  logic ferr_prev = 1'b0;
  logic [2:0]  wa [64];
  logic [15:0] wd [64];

  ov7670_capture #(.H_PIXELS(4), .V_LINES(2), .ADDR_W(3)) dut (
    .SYS_CLK(clk), .RST_N(rst_n), .RUN_EN(run_en), .CAM_PCLK(pclk), .CAM_VSYNC(vsync),
    .CAM_HREF(href), .CAM_DATA(cdata), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .WR_FRAME(wr_frame), .FRAME_ERR(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en && nw < 64) begin
      wa[nw] = wr_addr;
      wd[nw] = wr_data;
    end
    if (wr_en) nw++;
    if (frame_err) errcnt++;
    if (frame_err && ferr_prev) errlong++;
    ferr_prev = frame_err;
  end

  task automatic clear_log();
    @(negedge clk);
    #1;
    nw = 0;
    errcnt = 0;
    errlong = 0;
  endtask

  task automatic pclk_cycle(input logic hr, input logic [7:0] d);
    @(negedge clk);
    pclk = 1'b0;
    href = hr;
    cdata = d;
    repeat (2) @(negedge clk);
    pclk = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_line(input int nbytes, input int start);
    for (int i = 0; i < nbytes; i++) pclk_cycle(1'b1, 8'(start + i));
    repeat (3) pclk_cycle(1'b0, 8'h00);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    repeat (3) pclk_cycle(1'b0, 8'h00);
    vsync = 1'b0;
    repeat (3) pclk_cycle(1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) pclk_cycle(1'b1, 8'hAA);
    n_tests++;
    if ({wr_en, wr_frame, frame_err, wr_addr, wr_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b fr=%b err=%b a=%0d d=%h, want all 0",
               wr_en, wr_frame, frame_err, wr_addr, wr_data);
    end
    rst_n = 1'b1;
    clear_log();
    vsync_pulse();
    send_line(8, 0);
    send_line(8, 8);
    n_tests++;
    if (nw !== 0 || wr_frame !== 1'b0 || errcnt !== 0) begin
      n_fail++;
      $display("FAIL idle_quiet: writes=%0d fr=%b errs=%0d, want 0 0 0", nw, wr_frame, errcnt);
    end
  endtask

  task automatic test_full_frame();
    clear_log();
    run_en = 1'b1;
    repeat (2) @(negedge clk);
    vsync_pulse();
    send_line(8, 0);
    send_line(8, 8);
    n_tests++;
    if (nw !== 8) begin
      n_fail++;
      $display("FAIL full_count: got %0d writes, want 8", nw);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (wa[i] !== 3'(i) || wd[i] !== {8'(2 * i), 8'(2 * i + 1)}) begin
        n_fail++;
        $display("FAIL full_write%0d: got a=%0d d=%h, want a=%0d d=%h", i, wa[i], wd[i], i,
                 {8'(2 * i), 8'(2 * i + 1)});
      end
    end
    n_tests++;
    if (wr_frame !== 1'b1 || errcnt !== 0) begin
      n_fail++;
      $display("FAIL full_done: fr=%b errs=%0d, want 1 0", wr_frame, errcnt);
    end
    vsync_pulse();
    send_line(8, 8'h30);
    n_tests++;
    if (nw !== 8 || wr_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL done_hold: writes=%0d fr=%b, want 8 1", nw, wr_frame);
    end
    run_en = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (wr_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL done_clear: fr=%b, want 0", wr_frame);
    end
  endtask

  task automatic test_mid_frame();
    clear_log();
    pclk_cycle(1'b1, 8'hC0);
    pclk_cycle(1'b1, 8'hC1);
    run_en = 1'b1;
    for (int i = 2; i < 8; i++) pclk_cycle(1'b1, 8'(8'hC0 + i));
    repeat (3) pclk_cycle(1'b0, 8'h00);
    send_line(8, 8'hC8);
    n_tests++;
    if (nw !== 0) begin
      n_fail++;
      $display("FAIL mid_nowrite: got %0d writes, want 0", nw);
    end
    vsync_pulse();
    send_line(8, 8'h10);
    send_line(8, 8'h18);
    n_tests++;
    if (nw !== 8 || wa[0] !== 3'd0 || wd[0] !== 16'h1011 || wr_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_frame: writes=%0d a0=%0d d0=%h fr=%b, want 8 0 1011 1", nw, wa[0], wd[0],
               wr_frame);
    end
    run_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_overlong();
    clear_log();
    run_en = 1'b1;
    repeat (2) @(negedge clk);
    vsync_pulse();
    send_line(13, 8'h20);
    send_line(8, 8'h40);
    n_tests++;
    if (nw !== 8) begin
      n_fail++;
      $display("FAIL long_count: got %0d writes, want 8", nw);
    end
    n_tests++;
    if (wa[3] !== 3'd3 || wd[3] !== 16'h2627) begin
      n_fail++;
      $display("FAIL long_col3: got a=%0d d=%h, want a=3 d=2627", wa[3], wd[3]);
    end
    n_tests++;
    if (wa[4] !== 3'd4 || wd[4] !== 16'h4041 || wr_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL long_line2: got a=%0d d=%h fr=%b, want a=4 d=4041 fr=1", wa[4], wd[4], wr_frame);
    end
    run_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_short_frame();
    clear_log();
    run_en = 1'b1;
    repeat (2) @(negedge clk);
    vsync_pulse();
    send_line(8, 8'h50);
    send_line(2, 8'h60);
    vsync_pulse();
    n_tests++;
    if (errcnt !== 1 || errlong !== 0 || nw !== 5 || wr_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL short_err: errs=%0d long=%0d writes=%0d fr=%b, want 1 0 5 0", errcnt, errlong,
               nw, wr_frame);
    end
    send_line(8, 8'h70);
    send_line(8, 8'h78);
    n_tests++;
    if (nw !== 13 || wa[5] !== 3'd0 || wd[5] !== 16'h7071 || wa[12] !== 3'd7 || wr_frame !== 1'b1
        || errcnt !== 1) begin
      n_fail++;
      $display("FAIL short_restart: writes=%0d a5=%0d d5=%h a12=%0d fr=%b errs=%0d, want 13 0 7071 7 1 1",
               nw, wa[5], wd[5], wa[12], wr_frame, errcnt);
    end
    run_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    clear_log();
    run_en = 1'b1;
    repeat (2) @(negedge clk);
    vsync_pulse();
    send_line(6, 8'h80);
    run_en = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (nw !== 3 || wr_frame !== 1'b0 || errcnt !== 0) begin
      n_fail++;
      $display("FAIL abort_stop: writes=%0d fr=%b errs=%0d, want 3 0 0", nw, wr_frame, errcnt);
    end
    run_en = 1'b1;
    send_line(8, 8'h90);
    send_line(8, 8'h98);
    n_tests++;
    if (nw !== 3) begin
      n_fail++;
      $display("FAIL abort_wait: got %0d writes, want 3", nw);
    end
    vsync_pulse();
    send_line(8, 8'hA0);
    send_line(8, 8'hA8);
    n_tests++;
    if (nw !== 11 || wa[3] !== 3'd0 || wd[3] !== 16'hA0A1 || wr_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_resume: writes=%0d a3=%0d d3=%h fr=%b, want 11 0 a0a1 1", nw, wa[3], wd[3],
               wr_frame);
    end
    run_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_mid_frame();
    test_overlong();
    test_short_frame();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
